path_direction_executor: RTL and testbench

//  Consumer of the path planner's packed turn list. Latches the 2-bit-per-node direction vector at path start,

---
 rtl/path_direction_executor.sv | 118 +++++++++++
 tb/tb_path_direction_executor.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_direction_executor.sv
// Releases one turn command per detected node from a path vector latched at load.
// Each command is held on a valid/ack handshake, and the node sensor is blanked after every ack.
module path_direction_executor #(
  parameter int MAX_TURNS    = 12,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [2*MAX_TURNS-1:0] directions,
  input  logic [3:0]             num_turns,
  input  logic                   abort,
  input  logic                   node_detect,
  input  logic                   turn_ack,
  output logic                   turn_valid,
  output logic [1:0]             turn_cmd,
  output logic [3:0]             turn_index,
  output logic                   busy,
  output logic                   path_done,
  output logic                   overrun,
  output logic [1:0]             state_dbg
);

  // Handshake: turn_cmd is meaningful while turn_valid=1 and does not change
  // until the edge at which turn_ack=1 is sampled; that edge drops turn_valid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FOLLOW = 2'd1,
    S_TURN   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int BW = $clog2(BLANK_CYCLES + 1);

  state_t                 state;
  logic [2*MAX_TURNS-1:0] shadow;
  logic [3:0]             count;
  logic [BW-1:0]          blank;
  logic [3:0]             count_sat;
  logic [1:0]             cur_cmd;

  always_comb begin
    count_sat = (num_turns > 4'(MAX_TURNS)) ? 4'(MAX_TURNS) : num_turns;
    cur_cmd   = shadow[{turn_index, 1'b0} +: 2];
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shadow     <= '0;
      count      <= '0;
      blank      <= '0;
      turn_valid <= 1'b0;
      turn_cmd   <= 2'b00;
      turn_index <= '0;
      busy       <= 1'b0;
      path_done  <= 1'b0;
      overrun    <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      blank      <= '0;
      turn_valid <= 1'b0;
      busy       <= 1'b0;
      path_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      path_done <= 1'b0;
      // The re-arm window keeps draining outside FOLLOW so a fresh path is not stalled by it.
      if (blank != '0) blank <= blank - BW'(1);
      case (state)
        S_IDLE: begin
          if (load) begin
            shadow     <= directions;
            count      <= count_sat;
            turn_index <= '0;
            overrun    <= 1'b0;
            if (count_sat == 4'd0) begin
              state     <= S_DONE;
              path_done <= 1'b1;
            end else begin
              state <= S_FOLLOW;
              busy  <= 1'b1;
            end
          end
        end
        S_FOLLOW: begin
          if (node_detect && blank == '0) begin
            turn_cmd   <= cur_cmd;
            turn_valid <= 1'b1;
            state      <= S_TURN;
          end
        end
        S_TURN: begin
          if (node_detect) overrun <= 1'b1;
          if (turn_ack) begin
            turn_valid <= 1'b0;
            blank      <= BW'(BLANK_CYCLES);
            turn_index <= turn_index + 4'd1;
            if (turn_index + 4'd1 == count) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              path_done <= 1'b1;
            end else begin
              state <= S_FOLLOW;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_direction_executor.sv
// Directed bench for path_direction_executor: each scenario task drives its stimulus
// and compares outputs against hand-computed values.
module tb_path_direction_executor;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [23:0] directions;
  logic [3:0]  num_turns;
  logic        abort;
  logic        node_detect;
  logic        turn_ack;
  logic        turn_valid;
  logic [1:0]  turn_cmd;
  logic [3:0]  turn_index;
  logic        busy;
  logic        path_done;
  logic        overrun;
  logic [1:0]  state_dbg;

  int vectors;
  int miscompares;

  path_direction_executor #(.MAX_TURNS(12), .BLANK_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .directions(directions),
    .num_turns(num_turns), .abort(abort), .node_detect(node_detect),
    .turn_ack(turn_ack), .turn_valid(turn_valid), .turn_cmd(turn_cmd),
    .turn_index(turn_index), .busy(busy), .path_done(path_done),
    .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges; outputs are sampled 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] dirs, input logic [3:0] n);
    directions = dirs;
    num_turns  = n;
    load       = 1'b1;
    tick(1);
    load       = 1'b0;
  endtask

  // Waits out the blanking window, reports a node, checks the command, then acks it.
  task automatic do_turn(input string name, input logic [1:0] exp_cmd, input logic [3:0] exp_idx);
    tick(18);
    node_detect = 1'b1;
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (turn_valid !== 1'b1 || turn_cmd !== exp_cmd || turn_index !== exp_idx || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_issue got valid=%b cmd=%b idx=%0d busy=%b exp valid=1 cmd=%b idx=%0d busy=1",
               name, turn_valid, turn_cmd, turn_index, busy, exp_cmd, exp_idx);
    end
    tick(2);
    vectors++;
    if (turn_valid !== 1'b1 || turn_cmd !== exp_cmd) begin
      miscompares++;
      $display("FAIL %s_hold got valid=%b cmd=%b exp valid=1 cmd=%b", name, turn_valid, turn_cmd, exp_cmd);
    end
    turn_ack = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    vectors++;
    if (turn_valid !== 1'b0 || turn_index !== exp_idx + 4'd1) begin
      miscompares++;
      $display("FAIL %s_ack got valid=%b idx=%0d exp valid=0 idx=%0d", name, turn_valid, turn_index, exp_idx + 4'd1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; directions = '0; num_turns = '0;
    abort = 1'b0; node_detect = 1'b0; turn_ack = 1'b0;
    tick(2);
    vectors++;
    if ({turn_valid, turn_cmd, turn_index, busy, path_done, overrun, state_dbg} !== 12'b0) begin
      miscompares++;
      $display("FAIL reset got valid=%b cmd=%b idx=%0d busy=%b done=%b ovr=%b st=%0d exp all 0",
               turn_valid, turn_cmd, turn_index, busy, path_done, overrun, state_dbg);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    do_load(24'h000039, 4'd4);
    vectors++;
    if (busy !== 1'b1 || state_dbg !== 2'd1 || turn_valid !== 1'b0 || path_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_start got busy=%b st=%0d valid=%b done=%b exp busy=1 st=1 valid=0 done=0",
               busy, state_dbg, turn_valid, path_done);
    end
    do_turn("basic0", 2'b01, 4'd0);
    do_turn("basic1", 2'b10, 4'd1);
    do_turn("basic2", 2'b11, 4'd2);
    vectors++;
    if (path_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_done got %b exp 0", path_done);
    end
    do_turn("basic3", 2'b00, 4'd3);
    vectors++;
    if (path_done !== 1'b1 || busy !== 1'b0 || turn_index !== 4'd4) begin
      miscompares++;
      $display("FAIL basic_done got done=%b busy=%b idx=%0d exp done=1 busy=0 idx=4", path_done, busy, turn_index);
    end
    tick(1);
    vectors++;
    if (path_done !== 1'b0 || state_dbg !== 2'd0 || turn_index !== 4'd4) begin
      miscompares++;
      $display("FAIL basic_pulse got done=%b st=%0d idx=%0d exp done=0 st=0 idx=4", path_done, state_dbg, turn_index);
    end
  endtask

  task automatic test_blanking;
    do_load(24'h000FFF, 4'd2);
    do_turn("blank0", 2'b11, 4'd0);
    tick(2);
    node_detect = 1'b1;  // edge ack+3
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (turn_valid !== 1'b0 || overrun !== 1'b0 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL blank_early got valid=%b ovr=%b st=%0d exp valid=0 ovr=0 st=1", turn_valid, overrun, state_dbg);
    end
    tick(12);
    node_detect = 1'b1;  // edge ack+16, last blanked edge
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (turn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_edge16 got valid=%b exp 0", turn_valid);
    end
    node_detect = 1'b1;  // edge ack+17, accepted
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (turn_valid !== 1'b1 || turn_cmd !== 2'b11 || turn_index !== 4'd1) begin
      miscompares++;
      $display("FAIL blank_edge17 got valid=%b cmd=%b idx=%0d exp valid=1 cmd=11 idx=1", turn_valid, turn_cmd, turn_index);
    end
    turn_ack = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    vectors++;
    if (path_done !== 1'b1 || turn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_done got done=%b valid=%b exp done=1 valid=0", path_done, turn_valid);
    end
    tick(1);
  endtask

  task automatic test_overrun;
    do_load(24'h000006, 4'd2);
    tick(18);
    node_detect = 1'b1;
    tick(1);
    node_detect = 1'b0;
    node_detect = 1'b1;
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || turn_valid !== 1'b1 || turn_cmd !== 2'b10 || turn_index !== 4'd0) begin
      miscompares++;
      $display("FAIL ovr_set got ovr=%b valid=%b cmd=%b idx=%0d exp ovr=1 valid=1 cmd=10 idx=0",
               overrun, turn_valid, turn_cmd, turn_index);
    end
    tick(3);
    turn_ack = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || turn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_sticky got ovr=%b valid=%b exp ovr=1 valid=0", overrun, turn_valid);
    end
    do_turn("ovr1", 2'b01, 4'd1);
    vectors++;
    if (path_done !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_done got done=%b ovr=%b exp done=1 ovr=1", path_done, overrun);
    end
    tick(1);
    do_load(24'h000003, 4'd1);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
    do_turn("ovr2", 2'b11, 4'd0);
    tick(1);
  endtask

  task automatic test_empty_and_saturate;
    logic [3:0] k;
    do_load(24'hFFFFFF, 4'd0);
    vectors++;
    if (path_done !== 1'b1 || busy !== 1'b0 || turn_valid !== 1'b0 || state_dbg !== 2'd3) begin
      miscompares++;
      $display("FAIL empty_done got done=%b busy=%b valid=%b st=%0d exp done=1 busy=0 valid=0 st=3",
               path_done, busy, turn_valid, state_dbg);
    end
    tick(1);
    vectors++;
    if (path_done !== 1'b0 || state_dbg !== 2'd0 || turn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_idle got done=%b st=%0d valid=%b exp done=0 st=0 valid=0", path_done, state_dbg, turn_valid);
    end
    do_load(24'hE4E4E4, 4'd15);
    for (int i = 0; i < 12; i++) begin
      k = 4'(i);
      do_turn("sat", k[1:0], k);
      vectors++;
      if (path_done !== (i == 11)) begin
        miscompares++;
        $display("FAIL sat_done_%0d got %b exp %b", i, path_done, (i == 11));
      end
    end
    vectors++;
    if (turn_index !== 4'd12 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_end got idx=%0d busy=%b exp idx=12 busy=0", turn_index, busy);
    end
    tick(1);
  endtask

  task automatic test_abort;
    do_load(24'h000039, 4'd4);
    do_turn("abort0", 2'b01, 4'd0);
    tick(18);
    node_detect = 1'b1;
    tick(1);
    node_detect = 1'b0;
    node_detect = 1'b1;
    tick(1);
    node_detect = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || turn_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre got ovr=%b valid=%b exp ovr=1 valid=1", overrun, turn_valid);
    end
    abort = 1'b1;
    turn_ack = 1'b1;
    tick(1);
    abort = 1'b0;
    turn_ack = 1'b0;
    vectors++;
    if (state_dbg !== 2'd0 || turn_valid !== 1'b0 || busy !== 1'b0 || path_done !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle got st=%0d valid=%b busy=%b done=%b ovr=%b exp st=0 valid=0 busy=0 done=0 ovr=0",
               state_dbg, turn_valid, busy, path_done, overrun);
    end
    tick(1);
    vectors++;
    if (path_done !== 1'b0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_nodone got done=%b st=%0d exp done=0 st=0", path_done, state_dbg);
    end
    do_load(24'h000039, 4'd2);
    do_turn("abort_r0", 2'b01, 4'd0);
    do_turn("abort_r1", 2'b10, 4'd1);
    vectors++;
    if (path_done !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart_done got %b exp 1", path_done);
    end
    tick(1);
  endtask

  task automatic test_reset_mid;
    do_load(24'h000039, 4'd4);
    tick(2);
    do_load(24'hFFFFFF, 4'd1);
    vectors++;
    if (busy !== 1'b1 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL busy_load got busy=%b st=%0d exp busy=1 st=1", busy, state_dbg);
    end
    do_turn("rm0", 2'b01, 4'd0);
    vectors++;
    if (path_done !== 1'b0 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL busy_load_count got done=%b st=%0d exp done=0 st=1", path_done, state_dbg);
    end
    turn_ack = 1'b1;
    tick(1);
    turn_ack = 1'b0;
    vectors++;
    if (turn_index !== 4'd1 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL stray_ack got idx=%0d st=%0d exp idx=1 st=1", turn_index, state_dbg);
    end
    rst_n = 1'b0;
    load  = 1'b1;
    tick(1);
    rst_n = 1'b1;
    load  = 1'b0;
    vectors++;
    if ({turn_valid, turn_cmd, turn_index, busy, path_done, overrun, state_dbg} !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_mid got valid=%b cmd=%b idx=%0d busy=%b done=%b ovr=%b st=%0d exp all 0",
               turn_valid, turn_cmd, turn_index, busy, path_done, overrun, state_dbg);
    end
    tick(1);
    vectors++;
    if (state_dbg !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle got st=%0d busy=%b exp st=0 busy=0", state_dbg, busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_blanking();
    test_overrun();
    test_empty_and_saturate();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
